// File: rtl/mash_dsm_pkg.sv
// Shared constants and helpers for the parameterised MASH 1-1-1 delta-sigma modulator.
package mash_dsm_pkg;

  typedef enum logic [1:0] {
    ORD_1 = 2'd1,
    ORD_2 = 2'd2,
    ORD_3 = 2'd3
  } order_t;

  localparam int              LFSR_W             = 15;
  localparam int              LFSR_TAP_A         = 14;
  localparam int              LFSR_TAP_B         = 13;
  localparam logic [14:0]     LFSR_SEED_DEFAULT  = 15'h0001;
  localparam logic signed [4:0] OUT_MIN          = -5'sd3;
  localparam logic signed [4:0] OUT_MAX          = 5'sd4;

  // An order input of 0 runs as a first-order modulator.
  function automatic order_t eff_order(input logic [1:0] o);
    order_t r;
    case (o)
      2'd2:    r = ORD_2;
      2'd3:    r = ORD_3;
      default: r = ORD_1;
    endcase
    return r;
  endfunction

  function automatic logic signed [4:0] widen(input logic b);
    return {4'b0000, b};
  endfunction

  function automatic logic signed [3:0] clamp_out(input logic signed [4:0] v);
    logic signed [4:0] r;
    if (v < OUT_MIN) begin
      r = OUT_MIN;
    end else if (v > OUT_MAX) begin
      r = OUT_MAX;
    end else begin
      r = v;
    end
    return r[3:0];
  endfunction

endpackage

// File: rtl/mash_accum.sv
// One MASH stage: modulo-2^WIDTH accumulator with registered carry-out.
module mash_accum #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             cin,
  input  logic [WIDTH-1:0] addend,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] total;

  always_comb begin
    total = {1'b0, sum} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (en) begin
      {cout, sum} <= total;
    end
  end

endmodule

// File: rtl/mash_dsm_param.sv
// MASH 1-1-1 modulator with selectable order, LFSR dither and divide-ratio output.
module mash_dsm_param
  import mash_dsm_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter int          NINT_W    = 8,
  parameter logic [14:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                en,
  input  logic [1:0]          order,
  input  logic                dither_en,
  input  logic [WIDTH-1:0]    frac_in,
  input  logic                frac_load,
  input  logic [NINT_W-1:0]   n_int,
  output logic signed [3:0]   out_data,
  output logic [NINT_W:0]     div_out,
  output logic                out_valid,
  output logic                div_err
);

  order_t                   eff;
  order_t                   order_q;
  logic                     change;
  logic                     step;
  logic                     dither;
  logic                     primed;
  logic [LFSR_W-1:0]        lfsr;
  logic [WIDTH-1:0]         frac_q;
  logic [WIDTH-1:0]         acc1, acc2, acc3;
  logic                     c1, c2, c3;
  logic                     c2_d, c3_d, c3_dd;
  logic signed [4:0]        mix;
  logic signed [3:0]        out_next;
  logic signed [NINT_W+1:0] div_sum;

  assign eff    = eff_order(order);
  assign change = (eff != order_q);
  assign step   = en && !change;
  assign dither = dither_en && lfsr[0];

  mash_accum #(.WIDTH(WIDTH)) u_acc1 (
    .clk(Clk), .reset(reset), .en(step), .clr(change),
    .cin(dither), .addend(frac_q), .sum(acc1), .cout(c1)
  );

  mash_accum #(.WIDTH(WIDTH)) u_acc2 (
    .clk(Clk), .reset(reset), .en(step), .clr(change),
    .cin(1'b0), .addend(acc1), .sum(acc2), .cout(c2)
  );

  mash_accum #(.WIDTH(WIDTH)) u_acc3 (
    .clk(Clk), .reset(reset), .en(step), .clr(change),
    .cin(1'b0), .addend(acc2), .sum(acc3), .cout(c3)
  );

  // Error-cancellation network: first and second differences of the later carries.
  always_comb begin
    case (order_q)
      ORD_2:   mix = widen(c1) + widen(c2) - widen(c2_d);
      ORD_3:   mix = widen(c1) + widen(c2) - widen(c2_d)
                   + widen(c3) - widen(c3_d) - widen(c3_d) + widen(c3_dd);
      default: mix = widen(c1);
    endcase
  end

  assign out_next = clamp_out(mix);
  assign div_sum  = $signed({2'b00, n_int})
                  + $signed({{(NINT_W-2){out_next[3]}}, out_next});

  always_ff @(posedge Clk) begin
    if (reset) begin
      order_q   <= ORD_1;
      lfsr      <= LFSR_SEED;
      frac_q    <= '0;
      c2_d      <= 1'b0;
      c3_d      <= 1'b0;
      c3_dd     <= 1'b0;
      primed    <= 1'b0;
      out_data  <= 4'sd0;
      div_out   <= '0;
      out_valid <= 1'b0;
      div_err   <= 1'b0;
    end else begin
      order_q <= eff;
      if (frac_load) begin
        frac_q <= frac_in;
      end
      if (change) begin
        c2_d      <= 1'b0;
        c3_d      <= 1'b0;
        c3_dd     <= 1'b0;
        primed    <= 1'b0;
        out_data  <= 4'sd0;
        out_valid <= 1'b0;
      end else if (en) begin
        c2_d      <= c2;
        c3_d      <= c3;
        c3_dd     <= c3_d;
        lfsr      <= {lfsr[LFSR_W-2:0], lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B]};
        primed    <= 1'b1;
        out_data  <= out_next;
        out_valid <= primed;
        // A negative ratio cannot be programmed; pin to zero and flag it.
        if (div_sum[NINT_W+1]) begin
          div_out <= '0;
          div_err <= 1'b1;
        end else begin
          div_out <= div_sum[NINT_W:0];
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mash_dsm_param.sv
// Self-checking bench: behavioural MASH model feeding a scoreboard, plus vector table and corner sequences.
module tb_mash_dsm_param;

  logic        Clk = 1'b0;
  logic        reset, en, dither_en, frac_load;
  logic [1:0]  order;
  logic [15:0] frac_in;
  logic [7:0]  n_int;
  logic [3:0]  out_data;
  logic [8:0]  div_out;
  logic        out_valid, div_err;

  mash_dsm_param #(.WIDTH(16), .NINT_W(8), .LFSR_SEED(15'h0001)) dut (
    .Clk(Clk), .reset(reset), .en(en), .order(order), .dither_en(dither_en),
    .frac_in(frac_in), .frac_load(frac_load), .n_int(n_int),
    .out_data(out_data), .div_out(div_out), .out_valid(out_valid), .div_err(div_err)
  );

  always #5 Clk = ~Clk;

  typedef struct { int o; int d; } exp_t;
  typedef struct {
    bit e; int ord; bit ld; logic [15:0] frac; int nint;
    bit xv; int xo; int xd;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[9];

  int n_chk = 0;
  int n_pass = 0;
  int g_ord, g_nint;
  bit g_dth;
  logic [15:0] g_frac;
  int sum_out, n_out, nz_cnt;

  // Reference model state
  int ma1, ma2, ma3, mc1, mc2, mc3, mc2d, mc3d, mc3dd, mfq, moq, mout, mdiv;
  bit mprim, mvalid, merr;
  logic [14:0] ml;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic model_edge(input bit r, input bit e, input bit ld);
    int eo, s1, s2, s3, d, t;
    eo = (g_ord == 0) ? 1 : g_ord;
    if (r) begin
      ma1 = 0; ma2 = 0; ma3 = 0; mc1 = 0; mc2 = 0; mc3 = 0;
      mc2d = 0; mc3d = 0; mc3dd = 0; mfq = 0; moq = 1;
      mout = 0; mdiv = 0; mprim = 0; mvalid = 0; merr = 0; ml = 15'h0001;
    end else begin
      if (eo != moq) begin
        ma1 = 0; ma2 = 0; ma3 = 0; mc1 = 0; mc2 = 0; mc3 = 0;
        mc2d = 0; mc3d = 0; mc3dd = 0; mout = 0; mvalid = 0; mprim = 0; moq = eo;
      end else if (e) begin
        d = (g_dth && ml[0]) ? 1 : 0;
        t = mc1;
        if (moq >= 2) t = t + mc2 - mc2d;
        if (moq == 3) t = t + mc3 - 2 * mc3d + mc3dd;
        s1 = ma1 + mfq + d;
        s2 = ma2 + ma1;
        s3 = ma3 + ma2;
        mc2d = mc2; mc3dd = mc3d; mc3d = mc3;
        mc1 = s1 / 65536; ma1 = s1 % 65536;
        mc2 = s2 / 65536; ma2 = s2 % 65536;
        mc3 = s3 / 65536; ma3 = s3 % 65536;
        mvalid = mprim; mprim = 1; mout = t;
        if (g_nint + t < 0) begin
          mdiv = 0; merr = 1;
        end else begin
          mdiv = g_nint + t;
        end
        ml = {ml[13:0], ml[14] ^ ml[13]};
      end else begin
        mvalid = 0;
      end
      if (ld) mfq = int'(g_frac);
    end
  endtask

  task automatic tick(input bit r, input bit e, input bit ld);
    exp_t x;
    reset = r; en = e; frac_load = ld; order = g_ord[1:0];
    dither_en = g_dth; frac_in = g_frac; n_int = g_nint[7:0];
    model_edge(r, e, ld);
    if (mvalid) sbq.push_back('{mout, mdiv});
    @(posedge Clk); #1;
    check("out_valid", int'(out_valid), int'(mvalid));
    check("div_err", int'(div_err), int'(merr));
    if (out_valid) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL scoreboard: output %0d with no pending expectation", $signed(out_data));
      end else begin
        x = sbq.pop_front();
        check("out_data", int'($signed(out_data)), x.o);
        check("div_out", int'(div_out), x.d);
        check("out_range", int'($signed(out_data) >= -3 && $signed(out_data) <= 4), 1);
        sum_out += $signed(out_data);
        n_out++;
        if (out_data != 4'd0) nz_cnt++;
      end
    end else begin
      check("held_out", int'($signed(out_data)), mout);
      check("held_div", int'(div_out), mdiv);
    end
  endtask

  initial begin
    int found, dsum;
    g_ord = 1; g_nint = 10; g_dth = 1'b0; g_frac = 16'h0000;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("rst_frac_q", int'(dut.frac_q), 0);
    check("rst_lfsr", int'(dut.lfsr), 1);
    check("rst_out", int'(out_data), 0);
    check("rst_div", int'(div_out), 0);

    // Order 1 with frac = 1/2: carry toggles every step, output lags one step.
    tbl[0] = '{1'b0, 1, 1'b1, 16'h8000, 10, 1'b0, 0, 0};
    tbl[1] = '{1'b1, 1, 1'b0, 16'h8000, 10, 1'b0, 0, 10};
    tbl[2] = '{1'b1, 1, 1'b0, 16'h8000, 10, 1'b1, 0, 10};
    tbl[3] = '{1'b1, 1, 1'b0, 16'h8000, 10, 1'b1, 1, 11};
    tbl[4] = '{1'b1, 1, 1'b0, 16'h8000, 10, 1'b1, 0, 10};
    tbl[5] = '{1'b0, 1, 1'b0, 16'h8000, 10, 1'b0, 0, 10};
    tbl[6] = '{1'b1, 1, 1'b0, 16'h8000, 10, 1'b1, 1, 11};
    tbl[7] = '{1'b1, 0, 1'b0, 16'h8000, 10, 1'b1, 0, 10};
    tbl[8] = '{1'b1, 1, 1'b0, 16'h8000, 0,  1'b1, 1, 1};
    for (int i = 0; i < 9; i++) begin
      g_ord = tbl[i].ord; g_frac = tbl[i].frac; g_nint = tbl[i].nint;
      tick(1'b0, tbl[i].e, tbl[i].ld);
      check($sformatf("vec%0d_valid", i), int'(out_valid), int'(tbl[i].xv));
      check($sformatf("vec%0d_out", i), int'($signed(out_data)), tbl[i].xo);
      check($sformatf("vec%0d_div", i), int'(div_out), tbl[i].xd);
    end

    sum_out = 0; n_out = 0; g_nint = 10;
    for (int i = 0; i < 1024; i++) tick(1'b0, 1'b1, 1'b0);
    check("ord1_count", n_out, 1024);
    check("ord1_sum", sum_out, 512);

    // Order 3, frac = 1/4: long-run sum tracks 65536/4, window edges add a few LSB.
    g_ord = 3; g_frac = 16'h4000;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    sum_out = 0; n_out = 0;
    for (int i = 0; i < 65536; i++) tick(1'b0, 1'b1, 1'b0);
    dsum = sum_out - 16384;
    check("ord3_sum_near_16384", int'(dsum >= -3 && dsum <= 3), 1);

    g_frac = 16'h0000;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    nz_cnt = 0; n_out = 0;
    for (int i = 0; i < 64; i++) tick(1'b0, 1'b1, 1'b0);
    check("zero_frac_nonzero_outputs", nz_cnt, 0);
    check("zero_frac_count", n_out, 63);

    // Dither only: close the window where no stage-2/3 carry is pending.
    g_dth = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    sum_out = 0; n_out = 0;
    for (int i = 0; i < 16384; i++) tick(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4096 && !(mc2 == 0 && mc3 == 0); k++) tick(1'b0, 1'b1, 1'b0);
    check("dither_window_closed", int'(mc2 == 0 && mc3 == 0), 1);
    tick(1'b0, 1'b1, 1'b0);
    dsum = (sum_out < 0) ? -sum_out : sum_out;
    check("dither_mean_bound", int'(dsum * 16384 <= n_out), 1);

    // Order 3 -> 2 mid-run with a simultaneous frac load.
    g_dth = 1'b0; g_frac = 16'h4000; g_ord = 3;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b0);
    g_ord = 2; g_frac = 16'h2000;
    tick(1'b0, 1'b1, 1'b1);
    check("chg_valid", int'(out_valid), 0);
    check("chg_out", int'($signed(out_data)), 0);
    check("chg_acc1", int'(dut.acc1), 0);
    check("chg_acc2", int'(dut.acc2), 0);
    check("chg_acc3", int'(dut.acc3), 0);
    check("chg_carries", int'({dut.c1, dut.c2, dut.c3}), 0);
    check("chg_delays", int'({dut.c2_d, dut.c3_d, dut.c3_dd}), 0);
    check("chg_frac_q", int'(dut.frac_q), 16'h2000);
    n_out = 0;
    for (int i = 0; i < 21; i++) tick(1'b0, 1'b1, 1'b0);
    check("ord2_resumed", n_out, 20);

    // Underflow: n_int = 2 with outputs down to -3.
    g_ord = 3; g_frac = 16'hFFFF; g_nint = 2;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) tick(1'b0, 1'b1, 1'b0);
    g_frac = 16'h3333; g_dth = 1'b1;
    tick(1'b0, 1'b1, 1'b1);
    found = 0;
    for (int k = 0; k < 8192 && found == 0; k++) begin
      tick(1'b0, 1'b1, 1'b0);
      if (out_valid && $signed(out_data) == -3) found = 1;
    end
    check("neg3_seen", found, 1);
    if (found == 1) begin
      check("neg3_div_out", int'(div_out), 0);
      check("neg3_div_err", int'(div_err), 1);
    end
    g_nint = 100;
    for (int i = 0; i < 50; i++) tick(1'b0, 1'b1, 1'b0);
    check("div_err_sticky", int'(div_err), 1);

    // Reset mid-run with en and frac_load high.
    g_frac = 16'h1234;
    tick(1'b1, 1'b1, 1'b1);
    check("mid_rst_out", int'(out_data), 0);
    check("mid_rst_div", int'(div_out), 0);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_err", int'(div_err), 0);
    check("mid_rst_frac_q", int'(dut.frac_q), 0);
    check("mid_rst_lfsr", int'(dut.lfsr), 1);
    g_ord = 1;
    tick(1'b0, 1'b1, 1'b0);
    check("first_edge_invalid", int'(out_valid), 0);
    tick(1'b0, 1'b1, 1'b0);
    check("second_edge_valid", int'(out_valid), 1);

    check("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
